// File: rtl/imem_loader_if.sv
// Load-stream and byte-lane write bus shared by imem_loader and its environment.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 9
);
    logic                  start;
    logic [ADDR_WIDTH:0]   word_count;
    logic [7:0]            s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [3:0]            lane_we;
    logic [ADDR_WIDTH-1:0] lane_addr;
    logic [7:0]            lane_din;
    logic                  cpu_hold;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, word_count, s_data, s_valid,
        input  s_ready, lane_we, lane_addr, lane_din, cpu_hold, busy, done, err
    );

    modport slave (
        input  start, word_count, s_data, s_valid,
        output s_ready, lane_we, lane_addr, lane_din, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Streams bytes into the four 512x8 instruction-memory lanes while holding the core in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per session.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
    localparam logic [31:0]         TIMEOUT = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH:0]   r_count;
    logic [1:0]            r_byte_idx;
    logic [ADDR_WIDTH-1:0] r_word_idx;
    logic [31:0]           r_idle;
    logic                  r_err;
    logic [3:0]            r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_din;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            r_xor;
`endif

    logic w_legal, w_last_byte, w_timeout;
    logic w_ready, w_busy, w_hold, w_done;
    logic w_accept, w_data_acc, w_start_ok, w_set_err;

    assign w_legal     = (bus.word_count != '0) && (bus.word_count <= DEPTH);
    assign w_last_byte = (r_byte_idx == 2'd3) && ({1'b0, r_word_idx} == (r_count - ONE));
    // Fires on the cycle whose edge would bring the idle count up to TIMEOUT_CYCLES.
    assign w_timeout   = (TIMEOUT != '0) && ((r_idle + 32'd1) == TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        w_busy     = 1'b0;
        w_hold     = 1'b1;
        w_done     = 1'b0;
        w_accept   = 1'b0;
        w_data_acc = 1'b0;
        w_start_ok = 1'b0;
        w_set_err  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_hold = 1'b0;
                if (bus.start) begin
                    if (w_legal) begin
                        w_start_ok = 1'b1;
                        w_next     = S_LOAD;
                    end else begin
                        w_set_err = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_ready    = 1'b1;
                w_busy     = 1'b1;
                w_accept   = bus.s_valid;
                w_data_acc = bus.s_valid;
                if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (w_last_byte) w_next = S_CHECK;
`else
                    if (w_last_byte) w_next = S_DONE;
`endif
                end else if (w_timeout) begin
                    w_set_err = 1'b1;
                    w_next    = S_IDLE;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                w_ready  = 1'b1;
                w_busy   = 1'b1;
                w_accept = bus.s_valid;
                if (w_accept) begin
                    if (bus.s_data == r_xor) begin
                        w_next = S_DONE;
                    end else begin
                        w_set_err = 1'b1;
                        w_next    = S_IDLE;
                    end
                end else if (w_timeout) begin
                    w_set_err = 1'b1;
                    w_next    = S_IDLE;
                end
            end
`endif
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_idle     <= '0;
            r_err      <= 1'b0;
            r_we       <= '0;
            r_addr     <= '0;
            r_din      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor      <= '0;
`endif
        end else begin
            r_we <= '0;
            if (w_start_ok) begin
                r_count    <= bus.word_count;
                r_byte_idx <= '0;
                r_word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_xor      <= '0;
`endif
            end
            if (w_data_acc) begin
                r_we       <= 4'b0001 << r_byte_idx;
                r_addr     <= r_word_idx;
                r_din      <= bus.s_data;
                r_byte_idx <= r_byte_idx + 2'd1;
                if (r_byte_idx == 2'd3) r_word_idx <= r_word_idx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_xor      <= r_xor ^ bus.s_data;
`endif
            end
            if (w_start_ok)     r_err <= 1'b0;
            else if (w_set_err) r_err <= 1'b1;
            if (w_accept || !w_busy) r_idle <= '0;
            else                     r_idle <= r_idle + 32'd1;
        end
    end

    assign bus.s_ready   = w_ready;
    assign bus.busy      = w_busy;
    assign bus.cpu_hold  = w_hold;
    assign bus.done      = w_done;
    assign bus.err       = r_err;
    assign bus.lane_we   = r_we;
    assign bus.lane_addr = r_addr;
    assign bus.lane_din  = r_din;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table vectors, hand sequences and random loads against a byte-stream model.
module tb_imem_loader;
    localparam int unsigned AW = 9;
    localparam int unsigned TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus ();
    imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [7:0] data; logic [3:0] we; logic [AW-1:0] addr; } vec_t;
    typedef struct { logic [AW:0] wc; logic err; } ill_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model: data byte n lands in lane n%4 at address n/4 one cycle after acceptance;
    // with the checksum option a final byte equal to the XOR of all data bytes completes the load.
    task automatic run_load(input int unsigned wc, input logic [7:0] img[$],
                            input int unsigned gap_pct, input logic [7:0] chk_mask);
        int unsigned total = 4 * wc;
        int unsigned n_in  = 4 * wc;
        int unsigned n_acc = 0;
        int unsigned idle_run = 0;
        logic [7:0]  x = '0;
        logic        acc;
        logic        bad = 1'b0;
        for (int unsigned i = 0; i < total; i++) x ^= img[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
        n_in = total + 1;
        bad  = (chk_mask != 8'h00);
`endif
        bus.start      = 1'b1;
        bus.word_count = (AW+1)'(wc);
        bus.s_valid    = 1'b0;
        step();
        bus.start = 1'b0;
        check("hold_after_start", 32'(bus.cpu_hold), 1);
        check("err_cleared_on_start", 32'(bus.err), 0);
        for (int unsigned cyc = 0; cyc < 20 * n_in + 100 && n_acc < n_in; cyc++) begin
            bus.s_valid = (idle_run >= 5) || ($urandom_range(99) >= gap_pct);
            bus.s_data  = (n_acc < total) ? img[n_acc] : (x ^ chk_mask);
            idle_run    = bus.s_valid ? 0 : idle_run + 1;
            check("s_ready_in_load", 32'(bus.s_ready), 1);
            check("busy_in_load", 32'(bus.busy), 1);
            acc = bus.s_valid;
            step();
            if (acc && n_acc < total) begin
                check("lane_we", 32'(bus.lane_we), 32'(4'b0001 << (n_acc % 4)));
                check("lane_addr", 32'(bus.lane_addr), n_acc / 4);
                check("lane_din", 32'(bus.lane_din), 32'(img[n_acc]));
            end else begin
                check("lane_we_quiet", 32'(bus.lane_we), 0);
            end
            if (acc) n_acc++;
            if (n_acc < n_in) check("no_early_done", 32'(bus.done), 0);
        end
        bus.s_valid = 1'b0;
        check("all_bytes_accepted", n_acc, n_in);
        check("end_done", 32'(bus.done), bad ? 0 : 1);
        check("end_hold", 32'(bus.cpu_hold), bad ? 0 : 1);
        check("end_s_ready", 32'(bus.s_ready), 0);
        check("end_err", 32'(bus.err), 32'(bad));
        step();
        check("post_done", 32'(bus.done), 0);
        check("post_hold", 32'(bus.cpu_hold), 0);
        check("post_we", 32'(bus.lane_we), 0);
        check("post_err", 32'(bus.err), 32'(bad));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[8];
        ill_t        ill[3];
        logic [7:0]  img[$];
        logic [7:0]  rnd[$];
        int unsigned wc;

        tbl = '{'{8'h13, 4'b0001, 9'd0}, '{8'h00, 4'b0010, 9'd0},
                '{8'h00, 4'b0100, 9'd0}, '{8'h00, 4'b1000, 9'd0},
                '{8'h93, 4'b0001, 9'd1}, '{8'h80, 4'b0010, 9'd1},
                '{8'h10, 4'b0100, 9'd1}, '{8'h00, 4'b1000, 9'd1}};
        ill = '{'{10'd0, 1'b1}, '{10'd513, 1'b1}, '{10'd1023, 1'b1}};
        foreach (tbl[i]) img.push_back(tbl[i].data);

        bus.start = 1'b0; bus.word_count = '0; bus.s_data = '0; bus.s_valid = 1'b0;

        // Reset, then idle with s_valid high.
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({bus.s_ready, bus.lane_we, bus.lane_addr, bus.lane_din,
                                    bus.cpu_hold, bus.busy, bus.done, bus.err}), 0);
        rst_n = 1'b1;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_outputs", 32'({bus.s_ready, bus.lane_we, bus.cpu_hold,
                                       bus.busy, bus.done, bus.err}), 0);
        end
        bus.s_valid = 1'b0;

`ifndef IMEM_LOADER_CHECKSUM_EN
        // Two-word image back-to-back from the vector table.
        bus.start = 1'b1; bus.word_count = 10'd2;
        step();
        bus.start = 1'b0;
        check("tbl_hold", 32'(bus.cpu_hold), 1);
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = tbl[i].data;
            check("tbl_s_ready", 32'(bus.s_ready), 1);
            step();
            check("tbl_we", 32'(bus.lane_we), 32'(tbl[i].we));
            check("tbl_addr", 32'(bus.lane_addr), 32'(tbl[i].addr));
            check("tbl_din", 32'(bus.lane_din), 32'(tbl[i].data));
            check("tbl_done", 32'(bus.done), (i == 7) ? 1 : 0);
        end
        bus.s_valid = 1'b0;
        step();
        check("tbl_done_fall", 32'(bus.done), 0);
        check("tbl_hold_fall", 32'(bus.cpu_hold), 0);

        // Same image with s_valid toggling.
        run_load(2, img, 50, 8'h00);
`endif

        // Illegal word counts keep the loader idle with err set.
        foreach (ill[i]) begin
            bus.start = 1'b1; bus.word_count = ill[i].wc;
            step();
            bus.start = 1'b0;
            check("ill_err", 32'(bus.err), 32'(ill[i].err));
            check("ill_idle", 32'({bus.s_ready, bus.cpu_hold, bus.busy}), 0);
            step();
            check("ill_stays_idle", 32'({bus.s_ready, bus.cpu_hold}), 0);
        end
        rnd = {};
        for (int i = 0; i < 4; i++) rnd.push_back(8'($urandom));
        run_load(1, rnd, 0, 8'h00);

        // Timeout: two bytes then silence; a mid-load start must be ignored.
        bus.start = 1'b1; bus.word_count = 10'd1;
        step();
        bus.start = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 8'hA5;
        step();
        bus.s_data = 8'h5A;
        step();
        bus.s_valid = 1'b0;
        check("to_second_write", 32'(bus.lane_we), 32'(4'b0010));
        for (int k = 1; k <= int'(TO); k++) begin
            bus.start = (k == 3);
            step();
            bus.start = 1'b0;
            check("to_hold", 32'(bus.cpu_hold), (k < int'(TO)) ? 1 : 0);
            check("to_err", 32'(bus.err), (k == int'(TO)) ? 1 : 0);
            check("to_no_done", 32'(bus.done), 0);
            check("to_no_write", 32'(bus.lane_we), 0);
        end
        step();
        check("to_err_sticky", 32'(bus.err), 1);
        check("to_idle", 32'({bus.s_ready, bus.cpu_hold}), 0);
        rnd = {};
        for (int i = 0; i < 8; i++) rnd.push_back(8'($urandom));
        run_load(2, rnd, 30, 8'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img = {8'h93, 8'h00, 8'hC0, 8'h00};
        run_load(1, img, 0, 8'h00);
        run_load(1, img, 0, 8'h53);
`endif

        // Randomized sessions.
        for (int s = 0; s < 20; s++) begin
            logic [7:0] mask;
            wc = $urandom_range(6, 1);
            rnd = {};
            for (int unsigned i = 0; i < 4 * wc; i++) rnd.push_back(8'($urandom));
            mask = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
`ifndef IMEM_LOADER_CHECKSUM_EN
            mask = 8'h00;
`endif
            run_load(wc, rnd, $urandom_range(70), mask);
        end

        // Full-depth load.
        rnd = {};
        for (int i = 0; i < 4 * (1 << AW); i++) rnd.push_back(8'($urandom));
        run_load(1 << AW, rnd, 0, 8'h00);

        // Asynchronous reset in the middle of a load.
        bus.start = 1'b1; bus.word_count = 10'd3;
        step();
        bus.start = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 8'h77;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1 check("midreset_outputs", 32'({bus.s_ready, bus.lane_we, bus.lane_addr, bus.lane_din,
                                          bus.cpu_hold, bus.busy, bus.done, bus.err}), 0);
        bus.s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("midreset_idle", 32'({bus.s_ready, bus.cpu_hold, bus.busy}), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
